// File: rtl/reg_file_mp.sv
// Multi-port register file: one write port, two registered read ports with
// write bypass, per-entry valid bits and a sequenced clear engine.
module reg_file_mp #(
  parameter  int WIDTH = 9,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_drop,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_valid_a,
  output logic             rd_hit_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid_b,
  output logic             rd_hit_b,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done
);

  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [AW-1:0]    ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid;

  logic wr_in_range;
  logic wr_acc;
  logic clearing;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
  assign wr_acc      = wr_en && (state == IDLE) && wr_in_range;
  assign clearing    = (state == CLEAR);

  // Clear sequencer: walks ptr from 0 to DEPTH-1, one entry per cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      ptr      <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      wr_drop  <= wr_en && !wr_acc;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writes are only accepted in IDLE, so they never collide with the clear.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid <= '0;
    end else if (clearing) begin
      mem[ptr]   <= '0;
      valid[ptr] <= 1'b0;
    end else if (wr_acc) begin
      mem[wr_addr]   <= wr_data;
      valid[wr_addr] <= 1'b1;
    end
  end

  logic [1:0]       rd_en_p;
  logic [AW-1:0]    rd_addr_p [2];
  logic [WIDTH-1:0] rd_data_p [2];
  logic [1:0]       rd_valid_p;
  logic [1:0]       rd_hit_p;

  assign rd_en_p      = {rd_en_b, rd_en_a};
  assign rd_addr_p[0] = rd_addr_a;
  assign rd_addr_p[1] = rd_addr_b;
  assign rd_data_a    = rd_data_p[0];
  assign rd_data_b    = rd_data_p[1];
  assign rd_valid_a   = rd_valid_p[0];
  assign rd_valid_b   = rd_valid_p[1];
  assign rd_hit_a     = rd_hit_p[0];
  assign rd_hit_b     = rd_hit_p[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic             in_range;
      logic [WIDTH-1:0] data;
      logic             vld;
      logic             hit;

      assign in_range       = {1'b0, rd_addr_p[gi]} < DEPTH_W;
      assign rd_data_p[gi]  = data;
      assign rd_valid_p[gi] = vld;
      assign rd_hit_p[gi]   = hit;

      // Priority: out of range / being cleared, then same-edge write, then array.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          data <= '0;
          vld  <= 1'b0;
          hit  <= 1'b0;
        end else begin
          vld <= rd_en_p[gi];
          if (rd_en_p[gi]) begin
            if (!in_range || (clearing && (ptr == rd_addr_p[gi]))) begin
              data <= '0;
              hit  <= 1'b0;
            end else if (wr_acc && (wr_addr == rd_addr_p[gi])) begin
              data <= wr_data;
              hit  <= 1'b1;
            end else begin
              data <= mem[rd_addr_p[gi]];
              hit  <= valid[rd_addr_p[gi]];
            end
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: vector table for basic reads/writes, then
// scoreboarded sequences for clear, drop, held request and mid-clear reset.
module tb_reg_file_mp;

  localparam int WIDTH = 9;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             wr_drop;
  logic             rd_en_a = 1'b0;
  logic [AW-1:0]    rd_addr_a = '0;
  logic [WIDTH-1:0] rd_data_a;
  logic             rd_valid_a, rd_hit_a;
  logic             rd_en_b = 1'b0;
  logic [AW-1:0]    rd_addr_b = '0;
  logic [WIDTH-1:0] rd_data_b;
  logic             rd_valid_b, rd_hit_b;
  logic             clr_req = 1'b0;
  logic             busy, clr_done;

  reg_file_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_drop(wr_drop),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_valid_a(rd_valid_a), .rd_hit_a(rd_hit_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .rd_valid_b(rd_valid_b), .rd_hit_b(rd_hit_b),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             hit;
  } rd_exp_t;

  typedef struct {
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             ra_en;
    logic [AW-1:0]    ra;
    logic             rb_en;
    logic [AW-1:0]    rb;
    logic [WIDTH-1:0] ea;
    logic             ha;
    logic [WIDTH-1:0] eb;
    logic             hb;
  } vec_t;

  int passed = 0;
  int total  = 0;

  rd_exp_t q_a[$];
  rd_exp_t q_b[$];

  logic [WIDTH-1:0] m_mem [DEPTH];
  logic [DEPTH-1:0] m_val;
  logic             m_busy;
  logic [AW-1:0]    m_ptr;

  int busy_cnt, done_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_val  = '0;
    m_busy = 1'b0;
    m_ptr  = '0;
    q_a.delete();
    q_b.delete();
  endtask

  function automatic rd_exp_t model_rd(input logic [AW-1:0] a, input logic acc);
    rd_exp_t r;
    if (m_busy && m_ptr == a) begin
      r.data = '0; r.hit = 1'b0;
    end else if (acc && wr_addr == a) begin
      r.data = wr_data; r.hit = 1'b1;
    end else begin
      r.data = m_mem[a]; r.hit = m_val[a];
    end
    return r;
  endfunction

  // One clock: push expected read results, advance the model, sample after the edge.
  task automatic step();
    logic acc, drop_exp, done_exp, en_a, en_b;
    rd_exp_t e;
    acc      = wr_en && !m_busy;
    drop_exp = wr_en && !acc;
    en_a     = rd_en_a;
    en_b     = rd_en_b;
    done_exp = 1'b0;
    if (rd_en_a) q_a.push_back(model_rd(rd_addr_a, acc));
    if (rd_en_b) q_b.push_back(model_rd(rd_addr_b, acc));
    if (m_busy) begin
      m_mem[m_ptr] = '0;
      m_val[m_ptr] = 1'b0;
      if (m_ptr == AW'(DEPTH - 1)) begin
        m_busy   = 1'b0;
        done_exp = 1'b1;
      end
      m_ptr = m_ptr + 1'b1;
    end else begin
      if (acc) begin
        m_mem[wr_addr] = wr_data;
        m_val[wr_addr] = 1'b1;
      end
      if (clr_req) begin
        m_busy = 1'b1;
        m_ptr  = '0;
      end
    end
    @(posedge clk);
    #1;
    chk("busy", busy, m_busy);
    chk("clr_done", clr_done, done_exp);
    chk("wr_drop", wr_drop, drop_exp);
    chk("rd_valid_a", rd_valid_a, en_a);
    chk("rd_valid_b", rd_valid_b, en_b);
    if (busy) busy_cnt++;
    if (clr_done) done_cnt++;
    if (en_a && q_a.size() > 0) begin
      e = q_a.pop_front();
      chk("rd_data_a", rd_data_a, e.data);
      chk("rd_hit_a", rd_hit_a, e.hit);
    end
    if (en_b && q_b.size() > 0) begin
      e = q_b.pop_front();
      chk("rd_data_b", rd_data_b, e.data);
      chk("rd_hit_b", rd_hit_b, e.hit);
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0; clr_req = 1'b0;
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs();
      rd_en_a = 1'b1; rd_addr_a = AW'(i);
      rd_en_b = 1'b1; rd_addr_b = AW'(DEPTH - 1 - i);
      step();
      chk("zero_a", {rd_hit_a, rd_data_a}, 0);
      chk("zero_b", {rd_hit_b, rd_data_b}, 0);
    end
    idle_inputs();
  endtask

  task automatic fill_all();
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs();
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = WIDTH'(i + 1);
      step();
    end
    idle_inputs();
  endtask

  function automatic vec_t mk(input logic we, input int wa, input int wd,
                              input logic ra_en, input int ra, input logic rb_en, input int rb,
                              input int ea, input logic ha, input int eb, input logic hb);
    vec_t v;
    v.we = we; v.wa = AW'(wa); v.wd = WIDTH'(wd);
    v.ra_en = ra_en; v.ra = AW'(ra); v.rb_en = rb_en; v.rb = AW'(rb);
    v.ea = WIDTH'(ea); v.ha = ha; v.eb = WIDTH'(eb); v.hb = hb;
    return v;
  endfunction

  vec_t tbl [12];

  initial begin
    for (int i = 0; i < DEPTH; i++) tbl[i] = mk(0, 0, 0, 1, i, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 3, 'h1A5, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 1, 3, 1, 2, 'h1A5, 1, 0, 0);
    tbl[10] = mk(1, 5, 'h0FF, 1, 5, 0, 0, 'h0FF, 1, 0, 0);
    tbl[11] = mk(0, 0, 0, 1, 5, 1, 3, 'h0FF, 1, 'h1A5, 1);

    model_reset();
    n_rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rd_a", {rd_valid_a, rd_hit_a, rd_data_a}, 0);
    chk("rst_drop_done", {wr_drop, clr_done}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // Basic reads, write-then-read, and same-edge bypass.
    foreach (tbl[i]) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_en_a = tbl[i].ra_en; rd_addr_a = tbl[i].ra;
      rd_en_b = tbl[i].rb_en; rd_addr_b = tbl[i].rb;
      step();
      if (tbl[i].ra_en) chk($sformatf("tbl%0d_a", i), {rd_hit_a, rd_data_a}, {tbl[i].ha, tbl[i].ea});
      if (tbl[i].rb_en) chk($sformatf("tbl%0d_b", i), {rd_hit_b, rd_data_b}, {tbl[i].hb, tbl[i].eb});
    end
    idle_inputs();

    // Fill, clear, and a write attempted mid-clear.
    fill_all();
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      if (i == 0) clr_req = 1'b1;
      if (i == 2) begin
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 9'h155;
      end
      if (i == 4) begin
        rd_en_a = 1'b1; rd_addr_a = 3'd3;
        rd_en_b = 1'b1; rd_addr_b = 3'd6;
      end
      step();
      if (i == 2) chk("drop_pulse", wr_drop, 1);
    end
    idle_inputs();
    chk("busy_cycles", busy_cnt, 8);
    chk("done_pulses", done_cnt, 1);
    read_all_zero();

    // Write together with clr_req, then clr_req held across completion.
    fill_all();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 9'h1FF; clr_req = 1'b1;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 11; i++) step();
    clr_req = 1'b0;
    for (int i = 0; i < 20 && m_busy; i++) step();
    chk("held_clr_idle", busy, 0);
    step();
    read_all_zero();

    // Reset during the 4th busy cycle aborts the clear.
    fill_all();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("busy_before_rst", busy, 1);
    n_rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", clr_done, 0);
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("no_done_in_rst", {busy, clr_done}, 0);
    end
    @(negedge clk);
    n_rst = 1'b1;
    step();
    chk("no_done_after_rst", clr_done, 0);
    read_all_zero();
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 9'h0AB;
    step();
    idle_inputs();
    rd_en_a = 1'b1; rd_addr_a = 3'd1;
    rd_en_b = 1'b1; rd_addr_b = 3'd1;
    step();
    chk("post_rst_a1", {rd_hit_a, rd_data_a}, {1'b1, 9'h0AB});
    chk("post_rst_b1", {rd_hit_b, rd_data_b}, {1'b1, 9'h0AB});
    idle_inputs();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
